// File: rtl/gcd_seq_ctrl.sv
// ---------------------------------------------------------------------------
// gcd_seq_ctrl
//
// Multi-cycle controller that computes GCD(a, b) by repeated subtraction on an
// external register file + ALU datapath. The controller owns every datapath
// control signal. The datapath controls are a Moore decode of the state
// register.
//
// Sequence: IDLE -> LOAD_A -> LOAD_B -> CMP -> {SUB_A | SUB_B} -> CMP ... -> DONE
// A zero operand skips the datapath and goes straight to DONE with a|b.
//
// Optional feature (compile-time macro GCD_TIMEOUT_EN):
//   When defined, an iteration counter limits the number of subtractions to
//   MAX_ITER. When the limit is reached the run ends early with err=1 and the
//   current REG_A value as the result. When undefined, err is tied to 0.
//
// Ports
//   clk, rst            : clock (rising edge), async active-low reset
//   start, a, b         : request and operands, accepted only in IDLE
//   busy, done, result  : status, one-cycle completion pulse, held result
//   err                 : timeout flag, valid with done
//   rf_read_data1       : register-file port 1 read data (combinational)
//   rf_read_addr1/2     : register-file read addresses
//   rf_write_addr/en    : register-file write port control
//   rf_write_data_sel   : 1 = const_val, 0 = ALU result
//   const_val           : constant driven into the register file
//   alu_sel, alu_oper   : ALU op2 select and operation (00 add,01 sub,10 and,11 or)
//   alu_is_zero         : ALU result == 0
//   alu_borrow          : subtract op1 < op2 (unsigned)
// ---------------------------------------------------------------------------
module gcd_seq_ctrl #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int REG_A     = 1,
    parameter int REG_B     = 2,
    parameter int MAX_ITER  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 err,
    input  logic [WIDTH-1:0]     rf_read_data1,
    output logic [ADDR_BITS-1:0] rf_read_addr1,
    output logic [ADDR_BITS-1:0] rf_read_addr2,
    output logic [ADDR_BITS-1:0] rf_write_addr,
    output logic                 rf_write_en,
    output logic                 rf_write_data_sel,
    output logic [WIDTH-1:0]     const_val,
    output logic                 alu_sel,
    output logic [1:0]           alu_oper,
    input  logic                 alu_is_zero,
    input  logic                 alu_borrow
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_CMP    = 3'd3;
    localparam logic [2:0] S_SUB_A  = 3'd4;
    localparam logic [2:0] S_SUB_B  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [1:0] OP_SUB = 2'b01;

    localparam logic [ADDR_BITS-1:0] ADDR_A = ADDR_BITS'(REG_A);
    localparam logic [ADDR_BITS-1:0] ADDR_B = ADDR_BITS'(REG_B);

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             err_q;
    logic             accept;
    logic             zero_op;
    logic             timeout_hit;

    assign accept  = (state == S_IDLE) && start;
    assign zero_op = (a == '0) || (b == '0);

`ifdef GCD_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_ITER) + 1;

    logic [CNT_W-1:0] iter_cnt;

    // Counts subtractions of the current run; the check happens in CMP, i.e.
    // just before another SUB state would be entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_cnt <= '0;
        end else if (accept) begin
            iter_cnt <= '0;
        end else if (state == S_SUB_A || state == S_SUB_B) begin
            iter_cnt <= iter_cnt + 1'b1;
        end
    end

    assign timeout_hit = (iter_cnt == CNT_W'(MAX_ITER));
`else
    logic unused_cfg;
    assign unused_cfg  = (MAX_ITER > 0);
    assign timeout_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = zero_op ? S_DONE : S_LOAD_A;
                end
            end
            S_LOAD_A: state_nx = S_LOAD_B;
            S_LOAD_B: state_nx = S_CMP;
            S_CMP: begin
                // Equality wins over the iteration limit: a run that converges
                // on the limit still completes cleanly.
                if (alu_is_zero) begin
                    state_nx = S_DONE;
                end else if (timeout_hit) begin
                    state_nx = S_DONE;
                end else if (alu_borrow) begin
                    state_nx = S_SUB_B;
                end else begin
                    state_nx = S_SUB_A;
                end
            end
            S_SUB_A: state_nx = S_CMP;
            S_SUB_B: state_nx = S_CMP;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State, operand latches, result and error registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // result only moves on a completing transition into DONE; both CMP exits
    // (converged or timed out) report the running A value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
        end else if (accept && zero_op) begin
            result_q <= a | b;
        end else if (state == S_CMP && (alu_is_zero || timeout_hit)) begin
            result_q <= rf_read_data1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (state == S_CMP && !alu_is_zero && timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Moore decode of datapath controls
    // -----------------------------------------------------------------------
    always_comb begin
        rf_read_addr1     = '0;
        rf_read_addr2     = '0;
        rf_write_addr     = '0;
        rf_write_en       = 1'b0;
        rf_write_data_sel = 1'b0;
        const_val         = '0;
        alu_sel           = 1'b0;
        alu_oper          = 2'b00;
        case (state)
            S_LOAD_A: begin
                rf_write_en       = 1'b1;
                rf_write_addr     = ADDR_A;
                rf_write_data_sel = 1'b1;
                const_val         = a_q;
            end
            S_LOAD_B: begin
                rf_write_en       = 1'b1;
                rf_write_addr     = ADDR_B;
                rf_write_data_sel = 1'b1;
                const_val         = b_q;
            end
            S_CMP: begin
                rf_read_addr1 = ADDR_A;
                rf_read_addr2 = ADDR_B;
                alu_oper      = OP_SUB;
            end
            S_SUB_A: begin
                rf_read_addr1 = ADDR_A;
                rf_read_addr2 = ADDR_B;
                alu_oper      = OP_SUB;
                rf_write_en   = 1'b1;
                rf_write_addr = ADDR_A;
            end
            S_SUB_B: begin
                rf_read_addr1 = ADDR_B;
                rf_read_addr2 = ADDR_A;
                alu_oper      = OP_SUB;
                rf_write_en   = 1'b1;
                rf_write_addr = ADDR_B;
            end
            default: ;
        endcase
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign result = result_q;
    assign err    = err_q;

endmodule
